// File: rtl/miss_handler.sv
// miss_handler: memory-side responder for the cache stall interface.
// Accepts D-cache write-through stores, D-cache misses and I-cache misses
// (in that priority), drives the single multicycle memory port, streams the
// 8-word refill block into the requesting cache and commits its tag.
//
// Optional feature: define MISS_CRITICAL_WORD_FIRST_EN to start each refill
// at the faulting word and wrap modulo 8; otherwise refills run words 0..7.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_miss/i_miss_addr         I-cache miss request (level) and address
//   d_miss/d_miss_addr         D-cache miss request (level) and address
//   d_wr/d_wr_addr/d_wr_data   D-cache store request (level), address, data
//   mem_en/mem_wr/mem_addr/mem_din   memory request port
//   mem_dout/mem_valid         memory read return (fixed latency MEM_LAT)
//   fill_we/fill_sel/fill_word/fill_data   cache data-array refill write
//   tag_we                     tag/valid commit for the block at fill_sel
//   i_stall/d_stall            CPU stall outputs
module miss_handler #(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_valid,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        tag_we,
  output logic        i_stall,
  output logic        d_stall
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("miss_handler: MEM_LAT must be in 1..7");
  end

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_ic;
  logic [3:0]  r_rc;
  logic        r_sel;
  logic [11:0] r_blk;
  logic [2:0]  r_start;

  logic [2:0]  w_i_start;
  logic [2:0]  w_d_start;
  logic        w_issue;
  logic        w_accept;
  logic [2:0]  w_issue_off;
  logic [2:0]  w_fill_off;
  logic        w_unused_addr_bits;

`ifdef MISS_CRITICAL_WORD_FIRST_EN
  assign w_i_start = i_miss_addr[3:1];
  assign w_d_start = d_miss_addr[3:1];
`else
  assign w_i_start = '0;
  assign w_d_start = '0;
`endif

  // Low address bits are only consumed in critical-word-first builds.
  assign w_unused_addr_bits = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

  // Issue runs while ic<8; returns are only accepted in FILL with rc<8.
  assign w_issue     = (r_state == S_FILL) && !r_ic[3];
  assign w_accept    = (r_state == S_FILL) && mem_valid && !r_rc[3];
  assign w_issue_off = r_start + r_ic[2:0];
  assign w_fill_off  = r_start + r_rc[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ic    <= '0;
      r_rc    <= '0;
      r_sel   <= 1'b0;
      r_blk   <= '0;
      r_start <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (d_wr) begin
            r_state <= S_WRITE;
            r_sel   <= 1'b1;
          end else if (d_miss) begin
            r_state <= S_FILL;
            r_sel   <= 1'b1;
            r_blk   <= d_miss_addr[15:4];
            r_start <= w_d_start;
            r_ic    <= '0;
            r_rc    <= '0;
          end else if (i_miss) begin
            r_state <= S_FILL;
            r_sel   <= 1'b0;
            r_blk   <= i_miss_addr[15:4];
            r_start <= w_i_start;
            r_ic    <= '0;
            r_rc    <= '0;
          end
        end
        S_WRITE: r_state <= S_DONE;
        S_FILL: begin
          if (w_issue) r_ic <= r_ic + 4'd1;
          if (w_accept) begin
            r_rc <= r_rc + 4'd1;
            if (r_rc == 4'd7) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ic    <= '0;
          r_rc    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    fill_we   = w_accept;
    fill_sel  = r_sel;
    fill_word = '0;
    fill_data = '0;
    tag_we    = w_accept && (r_rc == 4'd7);
    if (r_state == S_WRITE) begin
      mem_en   = 1'b1;
      mem_wr   = 1'b1;
      mem_addr = d_wr_addr;
      mem_din  = d_wr_data;
    end else if (w_issue) begin
      mem_en   = 1'b1;
      mem_addr = {r_blk, w_issue_off, 1'b0};
    end
    if (w_accept) begin
      fill_word = w_fill_off;
      fill_data = mem_dout;
    end
  end

  // The served requester sees its stall drop only in DONE.
  assign d_stall = (d_wr | d_miss) & ~((r_state == S_DONE) & r_sel);
  assign i_stall = i_miss & ~((r_state == S_DONE) & ~r_sel);

endmodule

// File: doc/miss_handler.md
# miss_handler

Memory-side responder for the CPU's cache stall interface. It accepts I-cache miss, D-cache miss and D-cache write-through store requests, and arbitrates them onto the single multicycle memory port. It streams each 8-word refill block back into the requesting cache's data array, then commits the tag. The CPU sees its `IF_stall` / `MEM_stall` held high until the request is served.

## Interface
- `MEM_LAT`, 4: memory read latency in cycles from `mem_en` to the matching `mem_valid`. Range 1..7.
- `clk  in  1`: sole clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `i_miss  in  1`: I-cache tag miss, level.
- `i_miss_addr  in  16`: faulting fetch address.
- `d_miss  in  1`: D-cache read or write miss, level.
- `d_miss_addr  in  16`: faulting data address.
- `d_wr  in  1`: store request (write-through), level.
- `d_wr_addr  in  16`: store address.
- `d_wr_data  in  16`: store data.
- `mem_en  out  1`: memory request strobe.
- `mem_wr  out  1`: 1 = write, 0 = read.
- `mem_addr  out  16`: memory word address.
- `mem_din  out  16`: memory write data.
- `mem_dout  in  16`: memory read data.
- `mem_valid  in  1`: `mem_dout` is valid this cycle.
- `fill_we  out  1`: write `fill_data` into the selected cache's data array.
- `fill_sel  out  1`: target cache, 0 = I-cache, 1 = D-cache.
- `fill_word  out  3`: word offset within the block.
- `fill_data  out  16`: refill word.
- `tag_we  out  1`: commit tag and valid bit for the block at `fill_sel`.
- `i_stall  out  1`: stall fetch.
- `d_stall  out  1`: stall MEM stage.

## Operation
- States: IDLE, WRITE, FILL, DONE. State, counters and the latched request (`sel`, `blk`, `start`) are registers. All outputs are combinational from these registers and the inputs.
- Block base is `addr[15:4]`. The word offset is `addr[3:1]`. Issued addresses are `{blk, off, 1'b0}`.
- Priority in IDLE:
  - `d_wr` → WRITE.
  - Else `d_miss` → FILL with `sel`=1 and `blk`=`d_miss_addr[15:4]`.
  - Else `i_miss` → FILL with `sel`=0 and `blk`=`i_miss_addr[15:4]`.
- WRITE, one cycle:
  - `mem_en`=1, `mem_wr`=1.
  - `mem_addr`=`d_wr_addr`, `mem_din`=`d_wr_data`.
  - Next state DONE.
- FILL:
  - Issue counter `ic` (0..8): while `ic`<8, drive `mem_en`=1, `mem_wr`=0, `mem_addr`={blk, (start+ic)[2:0], 0}, then increment `ic`.
  - Receive counter `rc` (0..8): on each `mem_valid`, drive `fill_we`=1, `fill_word`=(start+rc)[2:0], `fill_data`=`mem_dout`, then increment `rc`.
  - `tag_we`=1 in the same cycle as the 8th `fill_we`. Next state DONE.
- DONE, one cycle: next state IDLE unconditionally.
- Stall outputs:
  - `d_stall` = (`d_wr` | `d_miss`) & ~(state==DONE & `sel`==1).
  - `i_stall` = `i_miss` & ~(state==DONE & `sel`==0).
  - WRITE sets `sel`=1.
- A losing requester keeps its stall high and is served after DONE → IDLE.
- `mem_valid` in IDLE, WRITE or DONE, or when `rc`==8, is ignored.
- Requests that change or drop during FILL or WRITE are ignored; the latched `blk` and `sel` are used.

## Timing
- Reset values: state IDLE, `ic`=`rc`=0, `sel`=0, `blk`=0, `start`=0. All outputs 0 except stalls, which follow the request inputs.
- Reset mid-fill aborts immediately. `tag_we` is never asserted, so the partial block remains invalid.
- Fill, with the request first seen in cycle 0:
  - Issues occur in cycles 1–8.
  - `fill_we` occurs in cycles 1+`MEM_LAT` .. 8+`MEM_LAT`.
  - `tag_we` occurs in cycle 8+`MEM_LAT`.
  - DONE is cycle 9+`MEM_LAT`, with the stall low.
  - IDLE is cycle 10+`MEM_LAT`.
- Store: WRITE in cycle 1, DONE in cycle 2 with `d_stall` low, IDLE in cycle 3.
- Memory latency is fixed. Issue is fully pipelined at one request per cycle, with no backpressure.

## Configuration
- `MISS_CRITICAL_WORD_FIRST_EN` defined:
  - `start` latches the faulting word offset `addr[3:1]`.
  - Issue and fill order wraps modulo 8 from that word.
- Not defined:
  - `start` is always 0.
  - Order is word 0..7.
- Stall release timing is identical in both modes: stalls drop only in DONE, never on the first word.

## Test plan
- Reset, then `i_miss`=1 with `i_miss_addr`=0x0024, `MEM_LAT`=4:
  - `mem_addr` 0x0020..0x002E in cycles 1–8.
  - `fill_we` in cycles 5–12 with `fill_sel`=0.
  - `tag_we` in cycle 12.
  - `i_stall` low in cycle 13.
- Macro defined, `d_miss` at 0x1236:
  - Issue order is words 3,4,5,6,7,0,1,2 (`mem_addr` 0x1236, 0x1238 … 0x1234).
  - `fill_word` follows the same order.
- `i_miss` and `d_miss` asserted in the same cycle:
  - D block filled first while `i_stall` stays high.
  - I fill begins issuing the cycle after IDLE.
  - `i_stall` drops 13 cycles after its fill starts.
- `d_wr` with addr 0x0100 and data 0xBEEF:
  - `mem_en`=`mem_wr`=1 with 0x0100/0xBEEF in cycle 1.
  - `d_stall`=0 in cycle 2.
  - No `fill_we`.
- Assert `rst_n` low in cycle 6 of a fill:
  - All counters clear and no `tag_we`.
  - After release, with the miss still high, the fill restarts from the first word.
- Spurious `mem_valid` in IDLE → no `fill_we` and no state change.
